// File: rtl/receiver_controller.sv
// receiver_controller: 16x-oversampled 8N1 UART receiver with valid/ack handshake and error flags (RX_PARITY_EN adds even parity)
module receiver_controller #(
  parameter int TICK_DIV0 = 651,
  parameter int TICK_DIV1 = 326,
  parameter int TICK_DIV2 = 54,
  parameter int TICK_DIV3 = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [1:0] S,
  input  logic       ser_in,
  input  logic       rd_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
`ifdef RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);
`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
  state_t state;
  logic [1:0] sync;
  logic [9:0] div, cnt, sel_div;
  logic [3:0] sub;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic rx, tick;
  assign rx = sync[1];
  assign tick = cnt == div - 10'd1;
  assign busy = state != IDLE;
  always_comb
    sel_div = S == 2'b00 ? 10'(TICK_DIV0) :
              S == 2'b01 ? 10'(TICK_DIV1) :
              S == 2'b10 ? 10'(TICK_DIV2) : 10'(TICK_DIV3);
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      sync <= 2'b11;
      div <= '0;
      cnt <= '0;
      sub <= '0;
      bit_idx <= '0;
      shift <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      sync <= {sync[0], ser_in};
      cnt <= (state == IDLE || tick) ? '0 : cnt + 10'd1;
      // clears first so that any flag set later in this cycle wins
      if (rd_ack) begin
        data_valid <= 1'b0;
        frame_err <= 1'b0;
        overrun <= 1'b0;
`ifdef RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      case (state)
        IDLE:
          if (!rx) begin
            state <= START;
            div <= sel_div;
            sub <= '0;
          end
        START:
          if (tick) begin
            sub <= sub + 4'd1;
            if (sub == 4'd7) begin
              state <= rx ? IDLE : DATA;
              sub <= '0;
              bit_idx <= '0;
            end
          end
        DATA:
          if (tick) begin
            sub <= sub + 4'd1;
            if (sub == 4'd15) begin
              shift <= {rx, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
`ifdef RX_PARITY_EN
              if (bit_idx == 3'd7) state <= PARITY;
`else
              if (bit_idx == 3'd7) state <= STOP;
`endif
            end
          end
`ifdef RX_PARITY_EN
        PARITY:
          if (tick) begin
            sub <= sub + 4'd1;
            if (sub == 4'd15) begin
              if (rx != ^shift) parity_err <= 1'b1;
              state <= STOP;
            end
          end
`endif
        STOP:
          if (tick) begin
            sub <= sub + 4'd1;
            if (sub == 4'd15) begin
              if (rx) begin
                data_out <= shift;
                data_valid <= 1'b1;
                if (data_valid && !rd_ack) overrun <= 1'b1;
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state <= BREAK;
              end
            end
          end
        BREAK:
          if (rx) state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end
endmodule
